// File: rtl/video_rx_unit.sv
// video_rx_unit
// Receive side of the TFT video link. Registers a parallel 4:4:4 RGB stream
// with HSync/VSync/DE, re-emits it as a pixel stream tagged with X/Y
// coordinates, and measures line/frame timing against the programmed values.
//
// Ports
//   iClk, iRst                 video clock, async active-low reset
//   iTftColorR/G/B, iTftHSync, iTftVSync, iTftDe   incoming video
//   iHdisplay, iHSyncMax       expected active width / line total-1
//   iVdisplay, iVSyncMax       expected active height / frame total-1
//   oPixel, oPixelVd, oPosX, oPosY, oSof           captured pixel stream
//   oHMax, oHactive, oVMax, oVactive               measured timing
//   oErr, oFrameDone, oLocked                      per-frame status
module video_rx_unit #(
  parameter int pHdisplayWidth = 11,
  parameter int pVdisplayWidth = 11,
  parameter bit pSyncActiveLow = 1'b1
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [3:0]                iTftColorR,
  input  logic [3:0]                iTftColorG,
  input  logic [3:0]                iTftColorB,
  input  logic                      iTftHSync,
  input  logic                      iTftVSync,
  input  logic                      iTftDe,
  input  logic [pHdisplayWidth:0]   iHdisplay,
  input  logic [pHdisplayWidth:0]   iHSyncMax,
  input  logic [pVdisplayWidth:0]   iVdisplay,
  input  logic [pVdisplayWidth:0]   iVSyncMax,
  output logic [11:0]               oPixel,
  output logic                      oPixelVd,
  output logic [pHdisplayWidth:0]   oPosX,
  output logic [pVdisplayWidth:0]   oPosY,
  output logic                      oSof,
  output logic [pHdisplayWidth:0]   oHMax,
  output logic [pHdisplayWidth:0]   oHactive,
  output logic [pVdisplayWidth:0]   oVMax,
  output logic [pVdisplayWidth:0]   oVactive,
  output logic [3:0]                oErr,
  output logic                      oFrameDone,
  output logic                      oLocked
);

  localparam logic [pHdisplayWidth:0] hOne = {{pHdisplayWidth{1'b0}}, 1'b1};
  localparam logic [pVdisplayWidth:0] vOne = {{pVdisplayWidth{1'b0}}, 1'b1};

  // Stage 1: input registers, sync normalised to active-high
  logic [11:0] rColor;
  logic        rHs, rVs, rDe;
  logic        rHsPrev, rVsPrev, rDePrev;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rColor  <= '0;
      rHs     <= 1'b0;
      rVs     <= 1'b0;
      rDe     <= 1'b0;
      rHsPrev <= 1'b0;
      rVsPrev <= 1'b0;
      rDePrev <= 1'b0;
    end else begin
      rColor  <= {iTftColorR, iTftColorG, iTftColorB};
      rHs     <= iTftHSync ^ pSyncActiveLow;
      rVs     <= iTftVSync ^ pSyncActiveLow;
      rDe     <= iTftDe;
      rHsPrev <= rHs;
      rVsPrev <= rVs;
      rDePrev <= rDe;
    end
  end

  logic hsEdge, vsEdge, deFall;
  assign hsEdge = rHs & ~rHsPrev;
  assign vsEdge = rVs & ~rVsPrev;
  assign deFall = ~rDe & rDePrev;

  // Measurement state
  logic [pHdisplayWidth:0] rHCnt, rDeCnt;
  logic [pVdisplayWidth:0] rVCnt, rVactCnt;
  logic [3:0]              rAcc;
  logic                    rHsSeen, rFrameSeen;
  logic [1:0]              rClean;

  logic                    hMaxErr, hActErr;
  logic [3:0]              accNext, errNow;
  logic [pVdisplayWidth:0] vactNext;
  logic [1:0]              cleanNext;

  // Events landing in the same cycle as the VS edge still belong to the
  // frame being closed, so the report is built from the "next" values.
  always_comb begin
    hMaxErr  = hsEdge & rHsSeen & (rHCnt != iHSyncMax);
    hActErr  = deFall & (rDeCnt != iHdisplay);
    accNext  = rAcc | {1'b0, hActErr, 1'b0, hMaxErr};
    vactNext = rVactCnt;
    if (deFall && (rVactCnt != '1)) vactNext = rVactCnt + vOne;
    errNow   = {(vactNext != iVdisplay), accNext[2], (rVCnt != iVSyncMax), accNext[0]};
    cleanNext = 2'd0;
    if (errNow == 4'd0) cleanNext = (rClean == 2'd2) ? 2'd2 : rClean + 2'd1;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rHCnt      <= '0;
      rDeCnt     <= '0;
      rVCnt      <= '0;
      rVactCnt   <= '0;
      rAcc       <= '0;
      rHsSeen    <= 1'b0;
      rFrameSeen <= 1'b0;
      rClean     <= '0;
      oHMax      <= '0;
      oHactive   <= '0;
      oVMax      <= '0;
      oVactive   <= '0;
      oErr       <= '0;
      oFrameDone <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;

      if (hsEdge) rHCnt <= '0;
      else if (rHCnt != '1) rHCnt <= rHCnt + hOne;

      if (hsEdge) begin
        rHsSeen <= 1'b1;
        if (rHsSeen) oHMax <= rHCnt;
      end

      if (deFall) begin
        rDeCnt   <= '0;
        oHactive <= rDeCnt;
      end else if (rDe && (rDeCnt != '1)) begin
        rDeCnt <= rDeCnt + hOne;
      end

      if (vsEdge) begin
        rVCnt      <= '0;
        rVactCnt   <= '0;
        rAcc       <= '0;
        rFrameSeen <= 1'b1;
        if (rFrameSeen) begin
          oVMax      <= rVCnt;
          oVactive   <= vactNext;
          oErr       <= errNow;
          oFrameDone <= 1'b1;
          rClean     <= cleanNext;
        end
      end else begin
        rVactCnt <= vactNext;
        rAcc     <= accNext;
        if (hsEdge && (rVCnt != '1)) rVCnt <= rVCnt + vOne;
      end
    end
  end

  assign oLocked = (rClean == 2'd2);

  // Stage 2: registered pixel stream
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oPixel   <= '0;
      oPixelVd <= 1'b0;
      oPosX    <= '0;
      oPosY    <= '0;
      oSof     <= 1'b0;
    end else begin
      oPixel   <= rColor;
      oPixelVd <= rDe;
      oPosX    <= rDeCnt;
      oPosY    <= rVactCnt;
      oSof     <= rDe & (rDeCnt == '0) & (rVactCnt == '0) & rFrameSeen;
    end
  end

endmodule

// File: tb/tb_video_rx_unit.sv
module tb_video_rx_unit;

  localparam bit SyncLow = 1'b1;
  localparam int HDisp = 32, HMaxExp = 112, VDisp = 32, VMaxExp = 57;

  logic        iClk, iRst;
  logic [3:0]  iTftColorR, iTftColorG, iTftColorB;
  logic        iTftHSync, iTftVSync, iTftDe;
  logic [11:0] iHdisplay, iHSyncMax, iVdisplay, iVSyncMax;
  logic [11:0] oPixel, oPosX, oPosY, oHMax, oHactive, oVMax, oVactive;
  logic        oPixelVd, oSof, oFrameDone, oLocked;
  logic [3:0]  oErr;

  video_rx_unit #(.pHdisplayWidth(11), .pVdisplayWidth(11), .pSyncActiveLow(SyncLow)) dut (
    .iClk(iClk), .iRst(iRst),
    .iTftColorR(iTftColorR), .iTftColorG(iTftColorG), .iTftColorB(iTftColorB),
    .iTftHSync(iTftHSync), .iTftVSync(iTftVSync), .iTftDe(iTftDe),
    .iHdisplay(iHdisplay), .iHSyncMax(iHSyncMax), .iVdisplay(iVdisplay), .iVSyncMax(iVSyncMax),
    .oPixel(oPixel), .oPixelVd(oPixelVd), .oPosX(oPosX), .oPosY(oPosY), .oSof(oSof),
    .oHMax(oHMax), .oHactive(oHactive), .oVMax(oVMax), .oVactive(oVactive),
    .oErr(oErr), .oFrameDone(oFrameDone), .oLocked(oLocked)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct { int pix; int x; int y; int sof; } pix_t;
  typedef struct { int hmax; int hact; int vmax; int vact; int err; int locked; } frame_t;

  pix_t   pixQ[$];
  frame_t frQ[$];
  int nChecks = 0, nErrs = 0;

  task automatic check(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nErrs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: timing derived from event timestamps and counts
  int  cyc = 0, lastHsCyc = 0;
  bit  prevHs, prevVs, prevDe, hsSeen, frameSeen;
  int  deRun, yLine, vEdges, acc, lastHMax, lastHact, clean;

  function automatic int sat(int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic modelReset();
    prevHs = 0; prevVs = 0; prevDe = 0; hsSeen = 0; frameSeen = 0;
    deRun = 0; yLine = 0; vEdges = 0; acc = 0; lastHMax = 0; lastHact = 0; clean = 0;
  endtask

  task automatic modelStep(bit hs, bit vs, bit de, logic [11:0] px);
    bit hsE, vsE, deF;
    int e, hm;
    hsE = hs && !prevHs;
    vsE = vs && !prevVs;
    deF = !de && prevDe;
    if (de) pixQ.push_back('{pix: int'(px), x: deRun, y: yLine,
                             sof: int'(deRun == 0 && yLine == 0 && frameSeen)});
    if (hsE) begin
      if (hsSeen) begin
        hm = sat(cyc - lastHsCyc - 1);
        lastHMax = hm;
        if (hm != HMaxExp) acc |= 1;
      end
      hsSeen = 1;
      lastHsCyc = cyc;
      if (!vsE) vEdges = sat(vEdges + 1);
    end
    if (deF) begin
      lastHact = deRun;
      if (deRun != HDisp) acc |= 4;
      yLine = sat(yLine + 1);
      deRun = 0;
    end else if (de) begin
      deRun = sat(deRun + 1);
    end
    if (vsE) begin
      if (frameSeen) begin
        e = acc | ((vEdges != VMaxExp) ? 2 : 0) | ((yLine != VDisp) ? 8 : 0);
        clean = (e == 0) ? ((clean >= 2) ? 2 : clean + 1) : 0;
        frQ.push_back('{hmax: lastHMax, hact: lastHact, vmax: vEdges, vact: yLine,
                        err: e, locked: int'(clean == 2)});
      end
      frameSeen = 1; acc = 0; vEdges = 0; yLine = 0;
    end
    prevHs = hs; prevVs = vs; prevDe = de;
    cyc++;
  endtask

  task automatic drive(bit hs, bit vs, bit de);
    logic [11:0] px;
    px = 12'($urandom);
    iTftHSync = hs ^ SyncLow;
    iTftVSync = vs ^ SyncLow;
    iTftDe = de;
    {iTftColorR, iTftColorG, iTftColorB} = px;
    modelStep(hs, vs, de, px);
    @(posedge iClk);
    #1;
  endtask

  task automatic line(int hb, int hd, int hf, bit deLine, bit vsAct);
    for (int i = 0; i < 30; i++) drive(1'b1, vsAct, 1'b0);
    for (int i = 0; i < hb; i++) drive(1'b0, vsAct, 1'b0);
    for (int i = 0; i < hd; i++) drive(1'b0, vsAct, deLine);
    for (int i = 0; i < hf; i++) drive(1'b0, vsAct, 1'b0);
  endtask

  // kind 1: one line with a short back porch; kind 2: last active line has 33 DE cycles
  task automatic frame(int kind, int errLine, int first, int last);
    int hb, hd, hf;
    for (int l = first; l < last; l++) begin
      hb = (kind == 1 && l == errLine) ? 42 : 43;
      hd = (kind == 2 && l == 45) ? 33 : 32;
      hf = (kind == 2 && l == 45) ? 7 : 8;
      line(hb, hd, hf, (l >= 14 && l < 46), (l < 10));
    end
  endtask

  task automatic shortLine(bit vsAct);
    drive(1'b1, vsAct, 1'b0);
    drive(1'b0, vsAct, 1'b0);
    drive(1'b0, vsAct, 1'b0);
  endtask

  task automatic checkResetOutputs(string tag);
    check({tag, " oPixelVd"}, int'(oPixelVd), 0);
    check({tag, " oPixel"}, int'(oPixel), 0);
    check({tag, " oPosX"}, int'(oPosX), 0);
    check({tag, " oHMax"}, int'(oHMax), 0);
    check({tag, " oVMax"}, int'(oVMax), 0);
    check({tag, " oErr"}, int'(oErr), 0);
    check({tag, " oFrameDone"}, int'(oFrameDone), 0);
    check({tag, " oLocked"}, int'(oLocked), 0);
  endtask

  // Monitor: pops expected items whenever the DUT presents a pixel or frame result
  pix_t   mp;
  frame_t mf;
  always @(negedge iClk) begin
    if (iRst) begin
      if (oPixelVd) begin
        if (pixQ.size() == 0) begin
          nChecks++; nErrs++;
          $display("FAIL pixel: unexpected valid pixel at x=%0d y=%0d", oPosX, oPosY);
        end else begin
          mp = pixQ.pop_front();
          check("oPixel", int'(oPixel), mp.pix);
          check("oPosX", int'(oPosX), mp.x);
          check("oPosY", int'(oPosY), mp.y);
          check("oSof", int'(oSof), mp.sof);
        end
      end
      if (oFrameDone) begin
        if (frQ.size() == 0) begin
          nChecks++; nErrs++;
          $display("FAIL frameDone: unexpected pulse, oErr=%0d", oErr);
        end else begin
          mf = frQ.pop_front();
          check("oHMax", int'(oHMax), mf.hmax);
          check("oHactive", int'(oHactive), mf.hact);
          check("oVMax", int'(oVMax), mf.vmax);
          check("oVactive", int'(oVactive), mf.vact);
          check("oErr", int'(oErr), mf.err);
          check("oLocked", int'(oLocked), mf.locked);
        end
      end
    end
  end

  initial begin
    int rl, nStuck;
    iRst = 1'b0;
    iHdisplay = 12'(HDisp); iHSyncMax = 12'(HMaxExp);
    iVdisplay = 12'(VDisp); iVSyncMax = 12'(VMaxExp);
    iTftHSync = ~SyncLow; iTftVSync = ~SyncLow; iTftDe = 1'b0;
    {iTftColorR, iTftColorG, iTftColorB} = '0;
    modelReset();
    repeat (3) @(posedge iClk);
    #1;
    checkResetOutputs("reset");
    iRst = 1'b1;

    frame(0, 0, 0, 58);                          // A: first VS, not evaluated
    frame(0, 0, 0, 58);                          // B
    frame(1, $urandom_range(1, 56), 0, 58);      // C: short line
    frame(0, 0, 0, 58);                          // D
    frame(0, 0, 0, 58);                          // E
    frame(2, 0, 0, 58);                          // F: 33-cycle DE line

    rl = $urandom_range(20, 40);
    frame(0, 0, 0, rl);                          // G: reset mid-frame
    iRst = 1'b0;
    #1;
    checkResetOutputs("midreset");
    iTftHSync = ~SyncLow; iTftVSync = ~SyncLow; iTftDe = 1'b0;
    modelReset();
    pixQ.delete();
    frQ.delete();
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b1;
    frame(0, 0, rl, 58);
    frame(0, 0, 0, 58);                          // H

    nStuck = $urandom_range(4200, 4400);         // VSync stuck inactive
    shortLine(1'b1);
    for (int i = 0; i < nStuck; i++) shortLine(1'b0);
    shortLine(1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0);

    check("pixel queue drained", pixQ.size(), 0);
    check("frame queue drained", frQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
